seq_detector_bcd: RTL
=====================

Name: seq_detector_bcd

Overview:
- Parametrised successor to the fixed 01[0*]1 Mealy sequence detector.
- Detects the serial pattern 0,1,0^k,1 on one input bit per clock. The gap length k can be bounded by a parameter.
- Overlap or non-overlap matching is selected at run time.
- Matches are counted in a saturating binary counter and in a parallel BCD counter that drives NUM_DIGITS 7-segment displays.
- Sits between the board input/debounce logic and the display pins.

Parameters:
- CNT_WIDTH, 8: width of the saturating binary match counter.
- NUM_DIGITS, 2: number of BCD digits and 7-segment display outputs (1..6).
- MAX_ZEROS, 0: maximum k in the gap. 0 means unbounded. Otherwise k must be <= MAX_ZEROS.
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit when its bit is 0. 0 means lit when 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  enable. 0 means the FSM and counters hold and z=0.
- clr  in  1  synchronous counter clear. Acts regardless of ena.
- overlap  in  1  1 means overlap matching, 0 means non-overlap.
- sig_to_test  in  1  serial bit under test, sampled on rising clk.
- z  out  1  Mealy match flag (combinational).
- count  out  CNT_WIDTH  binary match count.
- sat  out  1  high when count equals all-ones.
- disp  out  7*NUM_DIGITS  segment codes. Digit i occupies bits [7i+6:7i], with digit 0 as ones. Bit order within a digit is {g,f,e,d,c,b,a}.

Behaviour:
- Reset (rst=0, asynchronous): state=S_IDLE, zero counter zc=0, count=0, BCD digits=0, sat=0, z=0.
  - Every digit shows "0": 7'b1000000 when SEG_ACTIVE_LOW=1, 7'b0111111 when 0.
  - Reset asserted mid-stream aborts any partial match immediately.
- FSM states and transitions (evaluated only when ena=1; with ena=0 all state holds):
  - S_IDLE: bit 0 -> S_Z. Bit 1 -> S_IDLE.
  - S_Z (last bit was 0): bit 0 -> S_Z. Bit 1 -> S_ZO with zc=0.
  - S_ZO (seen 01, then zc zeros):
    - Bit 0 with MAX_ZEROS=0, or with zc<MAX_ZEROS -> S_ZO, zc+1. zc saturates at its maximum when unbounded.
    - Bit 0 with MAX_ZEROS!=0 and zc==MAX_ZEROS -> abort to S_Z (the last bit is 0).
    - Bit 1 -> match.
- Match: z = ena & (state==S_ZO) & sig_to_test. z is combinational in the same cycle as the final 1.
  - Next state after a match with overlap=0: S_IDLE.
  - Next state after a match with overlap=1 and zc>=1: S_ZO with zc=0. The trailing 0,1 forms a new prefix.
  - Next state after a match with overlap=1 and zc==0: S_IDLE.
- Counting:
  - On the clock edge that samples z=1, count increments by 1. It saturates at 2^CNT_WIDTH-1 and never wraps.
  - The BCD counter increments in parallel with decimal carry. It freezes at all 9s.
  - count, sat and disp change one edge after the match, i.e. visible the cycle after z.
- clr=1 on an edge: count=0, BCD=0, sat=0.
  - clr beats a simultaneous match: that match is not counted.
  - The FSM still advances normally.
- overlap may change on any cycle. It takes effect at the next match.
- disp is decoded combinationally from the BCD registers (digits 0-9 only).

Optional Feature:
- SEQ_DET_LZB_EN defined: leading-zero blanking.
  - Every digit above the most significant non-zero digit is driven fully unlit.
  - Digit 0 is always shown, so a count of 0 displays a single "0".
- Not defined: all NUM_DIGITS digits always display, including leading zeros.

Test Plan:
1. Defaults, overlap=0, ena=1. After reset, feed 000100110001011101010011 MSB first, one bit per clock.
   -> z pulses on bits 6, 13, 19, 23 (0-indexed). Final count=4. disp digit0 = "4", digit1 = "0".
2. Same stream with overlap=1.
   -> z pulses on bits 6, 7, 13, 14, 19, 22, 23. Final count=7.
3. MAX_ZEROS=1, overlap=0, same stream.
   -> the 0-gap of 2 at bits 4-5 aborts. z pulses on bits 7, 13, 19, 23. count=4.
4. CNT_WIDTH=4, NUM_DIGITS=1, overlap=0. Feed 20 repetitions of 011.
   -> count sticks at 15 with sat=1. disp digit0 sticks at "9".
   Then pulse clr for one cycle -> count=0, sat=0, disp "0".
5. Control and reset corners:
   - Drop ena for 3 cycles inside 0,1,0 -> state held and z=0 throughout. Resuming with 1 produces a match.
   - Assert clr on a match cycle -> count unchanged at 0.
   - Assert rst low mid-gap (after 0,1,0) -> all outputs reset at once. A following single 1 gives no match.
6. With SEQ_DET_LZB_EN, NUM_DIGITS=3, count=7 -> digits 2 and 1 fully unlit, digit 0 shows "7".
   Without the macro -> digits 2 and 1 show "0".

Source files
------------

// File: rtl/seq_detector_bcd.sv
// Serial 0,1,0^k,1 Mealy detector with saturating binary and BCD match counters
// driving NUM_DIGITS 7-segment displays. Define SEQ_DET_LZB_EN for leading-zero blanking.
module seq_detector_bcd #(
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned MAX_ZEROS      = 0,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      clr,
  input  logic                      overlap,
  input  logic                      sig_to_test,
  output logic                      z,
  output logic [CNT_WIDTH-1:0]      count,
  output logic                      sat,
  output logic [7*NUM_DIGITS-1:0]   disp
);

  // Unbounded gaps only need to know "zero" vs "at least one" zero.
  localparam int unsigned ZC_W = (MAX_ZEROS == 0) ? 1 : $clog2(MAX_ZEROS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_Z    = 2'd1,
    S_ZO   = 2'd2
  } state_t;

  state_t                          state, state_nxt;
  logic [ZC_W-1:0]                 zc, zc_nxt;
  logic                            gap_full;
  logic [NUM_DIGITS-1:0][3:0]      bcd, bcd_inc;
  logic                            bcd_full;
  logic                            carry;
  logic [6:0]                      seg;
`ifdef SEQ_DET_LZB_EN
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  logic                            seen_nz;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      zc    <= '0;
    end else begin
      state <= state_nxt;
      zc    <= zc_nxt;
    end
  end

  assign gap_full = (MAX_ZEROS != 0) && (zc == ZC_W'(MAX_ZEROS));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    zc_nxt    = zc;
    if (ena) begin
      case (state)
        S_IDLE: if (!sig_to_test) state_nxt = S_Z;
        S_Z: begin
          if (sig_to_test) begin
            state_nxt = S_ZO;
            zc_nxt    = '0;
          end
        end
        S_ZO: begin
          if (sig_to_test) begin
            // With overlap the last gap zero plus the matching 1 start a new prefix.
            if (overlap && (zc != '0)) begin
              state_nxt = S_ZO;
              zc_nxt    = '0;
            end else begin
              state_nxt = S_IDLE;
            end
          end else if (gap_full) begin
            state_nxt = S_Z;
          end else if (!(&zc)) begin
            zc_nxt = zc + ZC_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Mealy match output
  always_comb begin
    z = ena & (state == S_ZO) & sig_to_test;
  end

  // Decimal increment with carry, and the all-nines freeze condition
  always_comb begin
    bcd_inc  = bcd;
    carry    = 1'b1;
    bcd_full = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd[i] != 4'd9) bcd_full = 1'b0;
      if (carry) begin
        if (bcd[i] == 4'd9) begin
          bcd_inc[i] = 4'd0;
        end else begin
          bcd_inc[i] = bcd[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // Match counters; clear wins over a coincident match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      sat   <= 1'b0;
      bcd   <= '0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
      bcd   <= '0;
    end else if (z) begin
      if (!sat) count <= count + CNT_WIDTH'(1);
      if (count == ~CNT_WIDTH'(1)) sat <= 1'b1;
      if (!bcd_full) bcd <= bcd_inc;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Segment decode, scanning from the most significant digit down
  always_comb begin
    disp = '0;
    seg  = '0;
`ifdef SEQ_DET_LZB_EN
    seen_nz = 1'b0;
`endif
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      seg = seg7(bcd[i]);
      if (SEG_ACTIVE_LOW != 0) seg = ~seg;
`ifdef SEQ_DET_LZB_EN
      if (bcd[i] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz && (i != 0)) seg = SEG_OFF;
`endif
      disp[7*i +: 7] = seg;
    end
  end

endmodule
